// File: rtl/irq_timer_ctrl_pkg.sv
// Shared register offsets, TCON bit positions and IRQ sequencer state encoding.
// Imported by the interrupt/timer controller and its timer core.
package irq_timer_ctrl_pkg;

    localparam logic [4:0] OFS_TH      = 5'h00;
    localparam logic [4:0] OFS_TL      = 5'h04;
    localparam logic [4:0] OFS_TCON    = 5'h08;
    localparam logic [4:0] OFS_LED     = 5'h0C;
    localparam logic [4:0] OFS_DIGI    = 5'h10;
    localparam logic [4:0] OFS_SYSTICK = 5'h14;

    localparam int EN = 0;
    localparam int IE = 1;
    localparam int ST = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        SERV = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_timer_ctrl_if.sv
// CPU data-bus view of the register window: address/strobes in, read data and window hit out.
// Purely combinational signalling; the bus has no backpressure.
interface irq_timer_ctrl_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    logic [31:0] rdata;
    logic        hit;

    modport master (output addr, wdata, rd, wr, input rdata, hit);
    modport slave  (input addr, wdata, rd, wr, output rdata, hit);
endinterface

// File: rtl/irq_timer_ctrl_timer_core.sv
// TH/TL reload timer with EN/IE/ST control; overflow sets ST one clk after TL==FFFF_FFFF.
// Register writes commit on the next clk edge; never stalls the bus.
module irq_timer_ctrl_timer_core
    import irq_timer_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_th,
    input  logic        wr_tl,
    input  logic        wr_tcon,
    input  logic [31:0] wdata,
    output logic [31:0] th,
    output logic [31:0] tl,
    output logic        en,
    output logic        ie,
    output logic        st
);
    logic ovf;

    assign ovf = en && (tl == 32'hFFFF_FFFF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th <= '0;
            tl <= '0;
            en <= 1'b0;
            ie <= 1'b0;
            st <= 1'b0;
        end else begin
            // Reload samples the current TH, so a TH write in the same cycle lands afterwards.
            if (wr_th) th <= wdata;

            if (wr_tl)      tl <= wdata;
            else if (ovf)   tl <= th;
            else if (en)    tl <= tl + 32'd1;

            if (wr_tcon) begin
                en <= wdata[EN];
                ie <= wdata[IE];
            end

            // A hardware set beats a software clear landing in the same cycle.
            if (ovf && ie)                   st <= 1'b1;
            else if (wr_tcon && !wdata[ST])  st <= 1'b0;
        end
    end
endmodule

// File: rtl/irq_timer_ctrl.sv
// Memory-mapped timer/LED/7-seg/systick block with a non-nesting IRQ sequencer.
// Reads combinational, writes commit next edge, irq 2 clk after TL overflow; no backpressure.
module irq_timer_ctrl
    import irq_timer_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    irq_timer_ctrl_if.slave        bus,
    input  logic                   kernel,
    output logic                   irq,
    output logic [7:0]             led,
    output logic [11:0]            digi
);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_PEND = PEND;
    localparam logic [1:0] S_SERV = SERV;

    logic        hit;
    logic [4:0]  ofs;
    logic        wen;
    logic [31:0] th, tl, systick, rmux;
    logic        en, ie, st, req;
    logic [1:0]  state, state_nxt;

    assign hit     = (bus.addr[31:5] == BASE_ADDR[31:5]);
    assign ofs     = bus.addr[4:0];
    assign wen     = bus.wr & hit;
    assign bus.hit = hit;

    irq_timer_ctrl_timer_core timer_core (
        .clk     (clk),
        .reset   (reset),
        .wr_th   (wen && (ofs == OFS_TH)),
        .wr_tl   (wen && (ofs == OFS_TL)),
        .wr_tcon (wen && (ofs == OFS_TCON)),
        .wdata   (bus.wdata),
        .th      (th),
        .tl      (tl),
        .en      (en),
        .ie      (ie),
        .st      (st)
    );

    always_comb begin
        rmux = '0;
        case (ofs)
            OFS_TH:      rmux = th;
            OFS_TL:      rmux = tl;
            OFS_TCON:    rmux = {29'd0, st, ie, en};
            OFS_LED:     rmux = {24'd0, led};
            OFS_DIGI:    rmux = {20'd0, digi};
            OFS_SYSTICK: rmux = systick;
            default:     rmux = '0;
        endcase
    end

    assign bus.rdata = (bus.rd && hit) ? rmux : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led     <= '0;
            digi    <= '0;
            systick <= '0;
        end else begin
            systick <= systick + 32'd1;
            if (wen && (ofs == OFS_LED))  led  <= bus.wdata[7:0];
            if (wen && (ofs == OFS_DIGI)) digi <= bus.wdata[11:0];
        end
    end

    assign req = st & ie;

    // SERV is only entered with kernel high, so kernel low there is the eret.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req) state_nxt = S_PEND;
            S_PEND:  if (!req) state_nxt = S_IDLE;
                     else if (kernel) state_nxt = S_SERV;
            S_SERV:  if (!kernel) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    assign irq = (state == S_PEND) & ~kernel;
endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Directed plus randomized bench for irq_timer_ctrl against a cycle-level register model.
module tb_irq_timer_ctrl;
    import irq_timer_ctrl_pkg::*;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        kernel;
    logic        irq;
    logic [7:0]  led;
    logic [11:0] digi;

    irq_timer_ctrl_if bus ();

    irq_timer_ctrl #(.BASE_ADDR(BASE)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .kernel (kernel),
        .irq    (irq),
        .led    (led),
        .digi   (digi)
    );

    always #10 clk = ~clk;

    int n_chk = 0, n_pass = 0, n_fail = 0;

    // Reference model: architectural register contents as the spec defines them.
    logic [31:0] m_th, m_tl, m_tick;
    logic [2:0]  m_tcon;
    logic [7:0]  m_led;
    logic [11:0] m_digi;
    logic        m_irq;   // valid only while kernel stays low

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_th = '0; m_tl = '0; m_tick = '0; m_tcon = '0;
        m_led = '0; m_digi = '0; m_irq = 1'b0;
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        case (a[4:0])
            5'h00:   return m_th;
            5'h04:   return m_tl;
            5'h08:   return {29'd0, m_tcon};
            5'h0C:   return {24'd0, m_led};
            5'h10:   return {20'd0, m_digi};
            5'h14:   return m_tick;
            default: return 32'd0;
        endcase
    endfunction

    // One clock: compute next architectural state from the inputs held this cycle.
    task automatic tick();
        logic [31:0] a, d, n_th, n_tl;
        logic [2:0]  n_tcon;
        logic [7:0]  n_led;
        logic [11:0] n_digi;
        logic        we, wrap, n_irq;
        a  = bus.addr;
        d  = bus.wdata;
        we = bus.wr && (a[31:5] == BASE[31:5]);
        wrap  = m_tcon[0] && (m_tl == 32'hFFFF_FFFF);
        n_th  = (we && a[4:0] == 5'h00) ? d : m_th;
        n_tl  = m_tcon[0] ? (wrap ? m_th : m_tl + 32'd1) : m_tl;
        if (we && a[4:0] == 5'h04) n_tl = d;
        n_tcon = m_tcon;
        if (we && a[4:0] == 5'h08) n_tcon = {m_tcon[2] & d[2], d[1:0]};
        if (wrap && m_tcon[1]) n_tcon[2] = 1'b1;
        n_led  = (we && a[4:0] == 5'h0C) ? d[7:0]  : m_led;
        n_digi = (we && a[4:0] == 5'h10) ? d[11:0] : m_digi;
        // With kernel low, a request is presented exactly one clk after ST&IE is seen.
        n_irq  = m_tcon[2] & m_tcon[1];
        @(posedge clk);
        if (reset) begin
            m_th = n_th; m_tl = n_tl; m_tcon = n_tcon; m_led = n_led;
            m_digi = n_digi; m_irq = n_irq; m_tick = m_tick + 32'd1;
        end else begin
            model_clear();
        end
        @(negedge clk);
    endtask

    task automatic wr_reg(input logic [4:0] o, input logic [31:0] d);
        bus.addr = BASE | {27'd0, o}; bus.wdata = d; bus.wr = 1'b1; bus.rd = 1'b0;
        tick();
        bus.wr = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] o, input logic [31:0] exp);
        bus.addr = BASE | {27'd0, o}; bus.rd = 1'b1; bus.wr = 1'b0;
        #1;
        chk(tag, bus.rdata, exp);
        bus.rd = 1'b0;
    endtask

    initial begin
        logic [31:0] s0, ad, dd;
        int unsigned op;
        bus.addr = '0; bus.wdata = '0; bus.rd = 1'b0; bus.wr = 1'b0;
        kernel = 1'b0; reset = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_irq", irq, 0);
        chk("rst_led", led, 0);
        chk("rst_digi", digi, 0);
        for (int k = 0; k < 6; k++) rd_chk("rst_reg", 5'(k * 4), 32'd0);

        // Overflow: reload to TH, ST after 1 clk, irq after 2 clk.
        wr_reg(OFS_TH, 32'hFFFF_FFFC);
        wr_reg(OFS_TL, 32'hFFFF_FFFE);
        wr_reg(OFS_TCON, 32'd3);
        rd_chk("ovf_tl0", OFS_TL, 32'hFFFF_FFFE);
        tick();
        rd_chk("ovf_tlmax", OFS_TL, 32'hFFFF_FFFF);
        chk("ovf_irq0", irq, 0);
        tick();
        rd_chk("ovf_reload", OFS_TL, 32'hFFFF_FFFC);
        rd_chk("ovf_st", OFS_TCON, 32'd7);
        chk("ovf_irq1", irq, 0);
        tick();
        chk("ovf_irq2", irq, 1);

        // Trap taken: freeze timer keeping ST, kernel masks irq and moves to SERV.
        bus.addr = BASE | 32'h08; bus.wdata = 32'd6; bus.wr = 1'b1; kernel = 1'b1;
        #1;
        chk("kern_mask", irq, 0);
        tick();
        bus.wr = 1'b0;
        chk("serv_irq", irq, 0);
        chk("serv_state", dut.state, SERV);
        wr_reg(OFS_TCON, 32'd2);
        kernel = 1'b0;
        #1;
        chk("eret_irq", irq, 0);
        tick();
        chk("idle_irq0", irq, 0);
        chk("idle_state", dut.state, IDLE);
        tick();
        chk("idle_irq1", irq, 0);

        // Again, but return from the handler with ST still set.
        wr_reg(OFS_TL, 32'hFFFF_FFFF);
        wr_reg(OFS_TCON, 32'd3);
        tick();
        tick();
        chk("re_irq", irq, 1);
        bus.addr = BASE | 32'h08; bus.wdata = 32'd6; bus.wr = 1'b1; kernel = 1'b1;
        tick();
        bus.wr = 1'b0;
        tick();
        kernel = 1'b0;
        #1;
        chk("re_eret", irq, 0);
        tick();
        tick();
        chk("re_rearm", irq, 1);
        wr_reg(OFS_TCON, 32'd0);
        tick();
        chk("re_clr", irq, 0);

        // Software write colliding with the overflow cycle.
        for (int sc = 0; sc < 3; sc++) begin
            wr_reg(OFS_TH, 32'h100);
            wr_reg(OFS_TL, 32'hFFFF_FFFE);
            wr_reg(OFS_TCON, 32'd3);
            tick();
            if (sc == 0)      wr_reg(OFS_TCON, 32'd3);
            else if (sc == 1) wr_reg(OFS_TL, 32'd5);
            else              wr_reg(OFS_TH, 32'h77);
            rd_chk("col_tcon", OFS_TCON, 32'd7);
            rd_chk("col_tl", OFS_TL, (sc == 1) ? 32'd5 : 32'h100);
            rd_chk("col_th", OFS_TH, (sc == 2) ? 32'h77 : 32'h100);
            wr_reg(OFS_TCON, 32'd0);
            tick();
        end

        // LED/DIGI, out-of-window and unused offsets, simultaneous rd/wr.
        wr_reg(OFS_LED, 32'hA5);
        chk("led", led, 8'hA5);
        wr_reg(OFS_DIGI, 32'h3F1);
        chk("digi", digi, 12'h3F1);
        bus.addr = 32'h4000_0020; bus.wdata = 32'hFFFF_FFFF; bus.wr = 1'b1;
        #1;
        chk("out_hit", bus.hit, 0);
        tick();
        bus.wr = 1'b0;
        chk("out_led", led, 8'hA5);
        chk("out_digi", digi, 12'h3F1);
        rd_chk("out_th", OFS_TH, 32'h77);
        wr_reg(5'h1C, 32'hFFFF_FFFF);
        rd_chk("unused", 5'h1C, 32'd0);
        rd_chk("unused_tl", OFS_TL, m_tl);
        bus.addr = BASE | 32'h0C; bus.wdata = 32'h3C; bus.wr = 1'b1; bus.rd = 1'b1;
        #1;
        chk("rdwr_old", bus.rdata, 32'hA5);
        tick();
        bus.wr = 1'b0; bus.rd = 1'b0;
        chk("rdwr_new", led, 8'h3C);

        // SYSTICK free-runs and ignores writes.
        rd_chk("tick_a", OFS_SYSTICK, m_tick);
        bus.rd = 1'b1;
        #1;
        s0 = bus.rdata;
        bus.rd = 1'b0;
        repeat (10) tick();
        bus.rd = 1'b1;
        #1;
        chk("tick_diff", bus.rdata - s0, 32'd10);
        bus.rd = 1'b0;
        wr_reg(OFS_SYSTICK, 32'd0);
        rd_chk("tick_ro", OFS_SYSTICK, m_tick);

        // Random bus traffic, kernel low, against the model.
        for (int i = 0; i < 600; i++) begin
            op = $urandom_range(0, 3);
            ad = BASE | (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 9) == 0) ad = $urandom;
            case (ad[4:0])
                5'h04:   dd = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                5'h08:   dd = 32'($urandom_range(0, 7));
                default: dd = $urandom;
            endcase
            bus.addr = ad; bus.wdata = dd;
            bus.rd = (op == 0 || op == 2);
            bus.wr = (op == 1 || op == 2);
            #1;
            chk("rnd_hit", bus.hit, 32'(ad[31:5] == BASE[31:5]));
            if (bus.rd && ad[31:5] == BASE[31:5]) chk("rnd_rd", bus.rdata, model_rd(ad));
            chk("rnd_irq", irq, m_irq);
            chk("rnd_led", led, m_led);
            chk("rnd_digi", digi, m_digi);
            tick();
        end
        bus.wr = 1'b0; bus.rd = 1'b0;

        // Reset mid-count clears immediately.
        wr_reg(OFS_TCON, 32'd1);
        repeat (3) tick();
        reset = 1'b0;
        model_clear();
        rd_chk("arst_tl", OFS_TL, 32'd0);
        chk("arst_irq", irq, 0);
        chk("arst_led", led, 0);
        tick();
        reset = 1'b1;
        tick();
        rd_chk("arst_tcon", OFS_TCON, 32'd0);
        rd_chk("arst_tl2", OFS_TL, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
